// File: rtl/spi_frame_sequencer.sv
// Frame-level sequencer between the SPI slave byte shifter and the register file.
// First byte of each chip-select frame is a command; following bytes are burst write/read data.
module spi_frame_sequencer #(
    parameter int NUM_REGS = 12,
    parameter int AUTO_INC = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cs_n_i,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_byte_i,
    input  logic [7:0] reg_rd_data_i,
    output logic [3:0] reg_addr_o,
    output logic       reg_wr_en_o,
    output logic [7:0] reg_wr_data_o,
    output logic       reg_rd_en_o,
    output logic [7:0] tx_byte_o,
    output logic       tx_load_o,
    output logic       busy_o,
    output logic       cmd_err_o
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WRITE,
        RD_FETCH,
        RD_SEND,
        IGNORE
    } state_t;

    state_t     state_q;
    logic [3:0] reg_addr_q;
    logic       reg_wr_en_q;
    logic [7:0] reg_wr_data_q;
    logic       reg_rd_en_q;
    logic [7:0] tx_byte_q;
    logic       tx_load_q;
    logic       busy_q;
    logic       cmd_err_q;

    logic [3:0] addr_next_d;
    logic       cmd_illegal_d;

    // Wrap at the last implemented register so no out-of-range address is ever driven.
    always_comb begin
        addr_next_d = reg_addr_q;
        if (AUTO_INC != 0) begin
            if (reg_addr_q == 4'(NUM_REGS - 1)) begin
                addr_next_d = 4'd0;
            end else begin
                addr_next_d = reg_addr_q + 4'd1;
            end
        end
    end

    always_comb begin
        cmd_illegal_d = (rx_byte_i[6:4] != 3'b000) ||
                        ({1'b0, rx_byte_i[3:0]} >= 5'(NUM_REGS));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            reg_addr_q    <= 4'd0;
            reg_wr_en_q   <= 1'b0;
            reg_wr_data_q <= 8'h00;
            reg_rd_en_q   <= 1'b0;
            tx_byte_q     <= 8'h00;
            tx_load_q     <= 1'b0;
            busy_q        <= 1'b0;
            cmd_err_q     <= 1'b0;
        end else begin
            reg_wr_en_q <= 1'b0;
            reg_rd_en_q <= 1'b0;
            tx_load_q   <= 1'b0;

            if (state_q != IDLE && cs_n_i) begin
                // Frame abort: any byte completing in this cycle is dropped, address held.
                state_q   <= IDLE;
                busy_q    <= 1'b0;
                tx_byte_q <= 8'h00;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!cs_n_i) begin
                            state_q   <= CMD;
                            busy_q    <= 1'b1;
                            cmd_err_q <= 1'b0;
                            tx_byte_q <= 8'h00;
                            tx_load_q <= 1'b1;
                        end
                    end
                    CMD: begin
                        if (rx_valid_i) begin
                            if (cmd_illegal_d) begin
                                cmd_err_q <= 1'b1;
                                state_q   <= IGNORE;
                            end else begin
                                reg_addr_q <= rx_byte_i[3:0];
                                if (rx_byte_i[7]) begin
                                    reg_rd_en_q <= 1'b1;
                                    state_q     <= RD_FETCH;
                                end else begin
                                    state_q <= WRITE;
                                end
                            end
                        end
                    end
                    WRITE: begin
                        if (reg_wr_en_q) begin
                            reg_addr_q <= addr_next_d;
                        end else if (rx_valid_i) begin
                            reg_wr_en_q   <= 1'b1;
                            reg_wr_data_q <= rx_byte_i;
                        end
                    end
                    RD_FETCH: begin
                        // Read data is valid the cycle after the strobe; rx_valid here is ignored.
                        if (!reg_rd_en_q) begin
                            tx_byte_q <= reg_rd_data_i;
                            tx_load_q <= 1'b1;
                            state_q   <= RD_SEND;
                        end
                    end
                    RD_SEND: begin
                        if (rx_valid_i) begin
                            reg_addr_q  <= addr_next_d;
                            reg_rd_en_q <= 1'b1;
                            state_q     <= RD_FETCH;
                        end
                    end
                    IGNORE: begin
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign reg_addr_o    = reg_addr_q;
    assign reg_wr_en_o   = reg_wr_en_q;
    assign reg_wr_data_o = reg_wr_data_q;
    assign reg_rd_en_o   = reg_rd_en_q;
    assign tx_byte_o     = tx_byte_q;
    assign tx_load_o     = tx_load_q;
    assign busy_o        = busy_q;
    assign cmd_err_o     = cmd_err_q;

endmodule
